ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage. It consumes the ForwardA/ForwardB
//  selects from the forwarding unit and picks each operand from the regfile, MEM or WB.
//  It captures the operands, runs a fixed-latency shift-add / restoring-divide FSM and
//  stalls the front of the pipeline until the result is ready for the EX/MEM register.
// PARAMETERS
//  XLEN   32  datapath width; the iteration count equals XLEN
// PORTS
//  clk                  in   1     core clock, rising edge
//  reset_n              in   1     asynchronous, active-low reset
//  rs1_data             in   XLEN  regfile operand A (ID/EX register)
//  rs2_data             in   XLEN  regfile operand B (ID/EX register)
//  alu_result_mem       in   XLEN  forward value from the MEM stage
//  writeback_data_wb    in   XLEN  forward value from the WB stage
//  ForwardA             in   2     select A: 00 reg, 10 MEM, 01 WB, 11 treated as reg
//  ForwardB             in   2     select B: same encoding as ForwardA
//  md_valid             in   1     EX instruction is an M-extension op
//  md_funct3            in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  flush                in   1     kill the EX instruction (branch/exception)
//  md_stall             out  1     freeze PC/IF/ID/ID-EX and bubble into EX/MEM
//  md_done              out  1     one-cycle strobe: md_result is valid this cycle
//  md_result            out  XLEN  result; held until the next md_done
// BEHAVIOUR
//  - FSM states: IDLE, BUSY, DONE. A 5-bit (log2 XLEN) iteration counter is used.
//  - IDLE: when md_valid=1 and flush=0, capture the muxed operands and funct3, clear the
//    counter and go to BUSY. Forward inputs are ignored after capture; MEM/WB keep
//    draining while the pipeline is stalled, so they must not be sampled again.
//  - BUSY: one iteration per cycle. Go to DONE when the counter reaches XLEN-1.
//  - DONE: register the final result, md_done=1, go to IDLE. md_valid in this cycle
//    belongs to the same instruction and must not restart the FSM.
//  - Latency: issue at cycle T, BUSY for T+1..T+XLEN, DONE at T+XLEN+1. md_stall is high
//    for T..T+XLEN (33 cycles at XLEN=32). Back-to-back M ops start at T+XLEN+2 at the earliest.
//  - md_stall = (IDLE & md_valid & ~flush) | (BUSY & ~flush). It is combinational and
//    forced to 0 while reset_n=0.
//  - Signed ops: the FSM works on magnitudes; sign is applied at DONE.
//    - MUL returns the low XLEN bits.
//    - MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product.
//    - MULHSU treats rs1 as signed and rs2 as unsigned.
//    - Quotient sign = sA^sB. Remainder sign = sign of the dividend.
//  - Special cases keep the same fixed latency:
//    - divide by 0: DIV/DIVU give all-ones, REM/REMU return the dividend.
//    - DIV of -2^(XLEN-1) by -1 gives -2^(XLEN-1); REM of the same gives 0.
//  - Flush in any state: next state is IDLE, no md_done, md_result unchanged.
//  - Simultaneous flush and md_valid in IDLE: no capture, stay IDLE.
//  - Reset (async, any time): state IDLE, counter 0, md_result 0, md_done 0,
//    operand registers 0.
// TESTING
//  1. MUL, ForwardA=10 alu_result_mem=7, ForwardB=00 rs2=0xFFFFFFFD
//     -> md_done at T+33, md_result=0xFFFFFFEB, md_stall high for exactly 33 cycles.
//  2. Operands A=B=0xFFFFFFFF (one op per run):
//     MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//  3. ForwardB=01 writeback_data_wb=2, rs1=0xFFFFFFF9:
//     DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC.
//  4. Special cases (same 33-cycle latency each):
//     DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  5. Issue MUL 3*4 with ForwardA=10, then change alu_result_mem every BUSY cycle
//     -> result is still 12. A second op issued the cycle after DONE completes correctly.
//  6. flush at BUSY counter=10 -> IDLE next cycle, md_stall low, no md_done,
//     old md_result kept. reset_n low mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: forwarded operand capture,
// XLEN-cycle shift-add multiply / restoring divide, pipeline stall and result strobe.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_result_mem,
  input  logic [XLEN-1:0] writeback_data_wb,
  input  logic [1:0]      ForwardA,
  input  logic [1:0]      ForwardB,
  input  logic            md_valid,
  input  logic [2:0]      md_funct3,
  input  logic            flush,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_hi_q, acc_lo_q, b_q, result_q;
  logic [2:0]      f3_q;
  logic            neg_a_q, neg_b_q, b_zero_q;

  logic [XLEN-1:0]   op_a, op_b, mag_a, mag_b, final_value;
  logic              a_signed, b_signed, neg_a, neg_b, start;
  logic [XLEN:0]     add_sum, rem_shift, trial;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    op_a = rs1_data;
    op_b = rs2_data;
    case (ForwardA)
      2'b10:   op_a = alu_result_mem;
      2'b01:   op_a = writeback_data_wb;
      default: op_a = rs1_data;
    endcase
    case (ForwardB)
      2'b10:   op_b = alu_result_mem;
      2'b01:   op_b = writeback_data_wb;
      default: op_b = rs2_data;
    endcase
  end

  // Signed operands are reduced to magnitudes; the sign is reapplied once at DONE.
  assign a_signed = (md_funct3 == 3'b001) || (md_funct3 == 3'b010) ||
                    (md_funct3 == 3'b100) || (md_funct3 == 3'b110);
  assign b_signed = (md_funct3 == 3'b001) || (md_funct3 == 3'b100) ||
                    (md_funct3 == 3'b110);
  assign neg_a    = a_signed & op_a[XLEN-1];
  assign neg_b    = b_signed & op_b[XLEN-1];
  assign mag_a    = neg_a ? -op_a : op_a;
  assign mag_b    = neg_b ? -op_b : op_b;
  assign start    = (state_q == S_IDLE) & md_valid & ~flush;

  // Multiply: {acc_hi, acc_lo} shifts right, multiplier consumed from acc_lo[0].
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  assign add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign rem_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, b_q};

  assign prod   = {acc_hi_q, acc_lo_q};
  assign prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
  assign quo_s  = b_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q);
  assign rem_s  = neg_a_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    final_value = rem_s;
    case (f3_q)
      3'b000:                 final_value = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_value = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_value = quo_s;
      default:                final_value = rem_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY: begin
        if (flush)                   state_d = S_IDLE;
        else if (cnt_q == LAST_ITER) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign md_stall  = reset_n & (start | ((state_q == S_BUSY) & ~flush));
  assign md_done   = (state_q == S_DONE) & ~flush;
  assign md_result = md_done ? final_value : result_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_hi_q <= '0;
            acc_lo_q <= mag_a;
            b_q      <= mag_b;
            f3_q     <= md_funct3;
            neg_a_q  <= neg_a;
            neg_b_q  <= neg_b;
            b_zero_q <= (op_b == '0);
            cnt_q    <= '0;
          end
        end
        S_BUSY: begin
          if (!flush) begin
            cnt_q <= cnt_q + CW'(1);
            if (!f3_q[2]) begin
              acc_hi_q <= add_sum[XLEN:1];
              acc_lo_q <= {add_sum[0], acc_lo_q[XLEN-1:1]};
            end else if (!trial[XLEN]) begin
              acc_hi_q <= trial[XLEN-1:0];
              acc_lo_q <= {acc_lo_q[XLEN-2:0], 1'b1};
            end else begin
              acc_hi_q <= rem_shift[XLEN-1:0];
              acc_lo_q <= {acc_lo_q[XLEN-2:0], 1'b0};
            end
          end
        end
        S_DONE: begin
          if (!flush) result_q <= final_value;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed M-extension ops with hand-computed
// results, latency/stall checks, operand-capture, flush and async-reset behaviour.
module tb_ex_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rs1_data, rs2_data, alu_result_mem, writeback_data_wb;
  logic [1:0]  ForwardA, ForwardB;
  logic        md_valid, flush;
  logic [2:0]  md_funct3;
  logic        md_stall, md_done;
  logic [31:0] md_result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rs1_data          (rs1_data),
    .rs2_data          (rs2_data),
    .alu_result_mem    (alu_result_mem),
    .writeback_data_wb (writeback_data_wb),
    .ForwardA          (ForwardA),
    .ForwardB          (ForwardB),
    .md_valid          (md_valid),
    .md_funct3         (md_funct3),
    .flush             (flush),
    .md_stall          (md_stall),
    .md_done           (md_done),
    .md_result         (md_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every md_done strobe is matched against the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (md_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got result %h, expected no md_done", md_result);
        end else begin
          check("result", md_result, exp_q.pop_front());
        end
      end
    end
  end

  // Issue one op and hold md_valid until md_done; optionally scramble all operand
  // sources while BUSY to prove the captured operands are used.
  task automatic issue(input string name, input logic [2:0] f3, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] mem, input logic [31:0] wb,
                       input logic [31:0] exp, input bit scramble);
    int stall_cycles;
    int waited;
    @(negedge clk);
    rs1_data = r1; rs2_data = r2; alu_result_mem = mem; writeback_data_wb = wb;
    ForwardA = fa; ForwardB = fb; md_funct3 = f3; md_valid = 1'b1;
    exp_q.push_back(exp);
    last_exp = exp;
    stall_cycles = 0;
    waited = 0;
    #1;
    while (md_done !== 1'b1 && waited < 40) begin
      if (md_stall === 1'b1) stall_cycles++;
      @(negedge clk);
      #1;
      waited++;
      if (scramble) begin
        alu_result_mem = $urandom; writeback_data_wb = $urandom;
        rs1_data = $urandom; rs2_data = $urandom;
      end
    end
    check({name, "_latency"}, waited, 33);
    check({name, "_stall_cycles"}, stall_cycles, 33);
    md_valid = 1'b0;
  endtask

  initial begin
    int done_seen;
    reset_n = 1'b0; md_valid = 1'b0; flush = 1'b0; md_funct3 = '0;
    ForwardA = '0; ForwardB = '0;
    rs1_data = '0; rs2_data = '0; alu_result_mem = '0; writeback_data_wb = '0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    check("reset_result", md_result, 32'h0);
    check("reset_done", {31'b0, md_done}, 32'h0);
    md_valid = 1'b1;
    #1;
    check("reset_stall_gated", {31'b0, md_stall}, 32'h0);
    md_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // MUL with A from MEM, B from regfile.
    issue("mul_fwd_mem", F_MUL, 2'b10, 2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFFD,
          32'd7, 32'h55, 32'hFFFF_FFEB, 1'b0);

    // High-half variants on all-ones operands.
    issue("mulhu", F_MULHU, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 1'b0);
    issue("mulh", F_MULH, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 1'b0);
    issue("mulhsu", F_MULHSU, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 1'b0);

    // Divides with B forwarded from WB.
    issue("div", F_DIV, 2'b00, 2'b01, 32'hFFFF_FFF9, 32'h1234, 32'h99, 32'd2, 32'hFFFF_FFFD, 1'b0);
    issue("rem", F_REM, 2'b00, 2'b01, 32'hFFFF_FFF9, 32'h1234, 32'h99, 32'd2, 32'hFFFF_FFFF, 1'b0);
    issue("divu", F_DIVU, 2'b00, 2'b01, 32'hFFFF_FFF9, 32'h1234, 32'h99, 32'd2, 32'h7FFF_FFFC, 1'b0);

    // Divide by zero and signed overflow.
    issue("divu_by0", F_DIVU, 2'b00, 2'b00, 32'd5, 32'd0, 0, 0, 32'hFFFF_FFFF, 1'b0);
    issue("remu_by0", F_REMU, 2'b00, 2'b00, 32'd5, 32'd0, 0, 0, 32'd5, 1'b0);
    issue("div_by0_neg", F_DIV, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd0, 0, 0, 32'hFFFF_FFFF, 1'b0);
    issue("rem_by0_neg", F_REM, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd0, 0, 0, 32'hFFFF_FFF9, 1'b0);
    issue("div_ovf", F_DIV, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000, 1'b0);
    issue("rem_ovf", F_REM, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0, 1'b0);

    // Operands captured once; sources scrambled while BUSY; back-to-back issue.
    issue("mul_capture", F_MUL, 2'b10, 2'b00, 32'h0BAD, 32'd4, 32'd3, 32'h0, 32'd12, 1'b1);
    issue("divu_b2b", F_DIVU, 2'b00, 2'b00, 32'd100, 32'd7, 0, 0, 32'd14, 1'b0);
    issue("mulhu_fwd11", F_MULHU, 2'b11, 2'b11, 32'h0001_0000, 32'h0001_0000,
          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0);

    // Flush together with md_valid in IDLE: nothing starts.
    @(negedge clk);
    md_funct3 = F_MUL; rs1_data = 32'd9; rs2_data = 32'd9; ForwardA = '0; ForwardB = '0;
    md_valid = 1'b1; flush = 1'b1;
    #1;
    check("idle_flush_stall", {31'b0, md_stall}, 32'h0);
    @(negedge clk);
    md_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_no_start", {31'b0, md_stall}, 32'h0);

    // Flush mid-BUSY at counter 10.
    @(negedge clk);
    md_funct3 = F_MUL; rs1_data = 32'd5; rs2_data = 32'd5; md_valid = 1'b1;
    repeat (11) @(negedge clk);
    #1;
    flush = 1'b1; md_valid = 1'b0;
    #1;
    check("busy_flush_stall", {31'b0, md_stall}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("after_flush_stall", {31'b0, md_stall}, 32'h0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done === 1'b1) done_seen++;
    end
    check("flush_no_done", done_seen, 0);
    check("flush_result_kept", md_result, last_exp);

    // Async reset mid-BUSY.
    @(negedge clk);
    md_funct3 = F_MULHU; rs1_data = 32'hFFFF_0000; rs2_data = 32'hFFFF_0000; md_valid = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_busy_stall", {31'b0, md_stall}, 32'h0);
    check("rst_busy_done", {31'b0, md_done}, 32'h0);
    check("rst_busy_result", md_result, 32'h0);
    @(negedge clk);
    md_valid = 1'b0;
    reset_n = 1'b1;

    issue("mul_after_reset", F_MUL, 2'b00, 2'b00, 32'd6, 32'd7, 0, 0, 32'd42, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
